// File: rtl/demux_select_driver.sv
// demux_select_driver: FIFO-buffered sequencer producing glitch-free select/data waveforms for a 4-way demux
module demux_select_driver #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_chan,
  input  logic                     in_data,
  output logic                     y,
  output logic                     x1,
  output logic                     x2,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, GAP} state_t;
  state_t state_q, state_d;
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          data_q, data_d, y_q, y_d, x1_q, x1_d, x2_q, x2_d, done_q, done_d;
  logic          push, pop;
  logic [2:0]    head;
  assign in_ready = count_q != CW'(DEPTH);
  assign busy     = state_q != IDLE;
  assign count    = count_q;
  assign y        = y_q;
  assign x1       = x1_q;
  assign x2       = x2_q;
  assign done     = done_q;
  // FIFO bookkeeping and FSM next state; selects only move while y is low
  always_comb begin
    push     = in_valid && in_ready;
    pop      = (state_q == IDLE || state_q == GAP) && count_q != '0;
    head     = mem_q[rd_ptr_q];
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    state_d  = state_q;
    hold_d   = hold_q;
    data_d   = data_q;
    y_d      = 1'b0;
    x1_d     = x1_q;
    x2_d     = x2_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        state_d = pop ? SETUP : IDLE;
        x1_d    = pop ? head[2] : 1'b0;
        x2_d    = pop ? head[1] : 1'b0;
        data_d  = pop ? head[0] : data_q;
      end
      SETUP: begin
        state_d = DRIVE;
        hold_d  = '0;
        y_d     = data_q;
      end
      DRIVE: begin
        state_d = hold_q == HW'(HOLD_CYCLES - 1) ? GAP : DRIVE;
        hold_d  = hold_q + 1'b1;
        y_d     = hold_q == HW'(HOLD_CYCLES - 1) ? 1'b0 : data_q;
        done_d  = hold_q == HW'(HOLD_CYCLES - 1);
      end
    endcase
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      data_q   <= 1'b0;
      y_q      <= 1'b0;
      x1_q     <= 1'b0;
      x2_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      data_q   <= data_d;
      y_q      <= y_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      done_q   <= done_d;
    end
  end
  // FIFO storage, written at the tail on an accepted request
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_chan, in_data};
  end
endmodule

// File: doc/demux_select_driver.md
Name: demux_select_driver

Overview:
- Upstream sequencer for the 4-way NOR-gate demultiplexer (inputs y, x1, x2; outputs z0..z3).
- Accepts {channel, data-bit} requests over a valid/ready handshake and buffers them in a small FIFO.
- Replays each request onto the demux as registered, glitch-free select/data waveforms: address set-up, data hold, then a gap.
- Channel index maps as {x1,x2}: z0=00, z1=01, z2=10, z3=11.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- HOLD_CYCLES, 2, cycles y carries the data bit per request; minimum 1.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  FIFO can accept (= !full, registered state).
- in_chan  input  2  target channel; bit1→x1, bit0→x2.
- in_data  input  1  data bit to route.
- y  output  1  demux data input, registered.
- x1  output  1  demux select MSB, registered.
- x2  output  1  demux select LSB, registered.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the GAP cycle of each request.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO emptied (count=0); state=IDLE.
  - y=x1=x2=0, busy=0, done=0, in_ready=1 after that edge.
  - Applies mid-operation: any in-flight request is abandoned and outputs return to 0 at the next edge.
- Push: on an edge with in_valid && in_ready, {in_chan,in_data} is written at the tail.
  - When full, in_ready=0 and in_valid is ignored (no overwrite, no drop flag).
- Pop occurs only on IDLE→SETUP or GAP→SETUP transitions.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - A push into an empty FIFO is not visible to the FSM until the following cycle (no bypass).
- FSM states: IDLE, SETUP, DRIVE, GAP.
  - IDLE: y=0, x1=x2=0. If count>0, pop the head, go to SETUP.
  - SETUP (1 cycle): x1,x2 = popped channel; y=0. Go to DRIVE.
  - DRIVE (HOLD_CYCLES cycles, internal counter): y = popped data; x1,x2 held. After the last cycle, go to GAP.
  - GAP (1 cycle): y=0, x1,x2 held, done=1.
    - If count>0, pop and go to SETUP (new x1,x2 loaded).
    - Otherwise go to IDLE (x1,x2 cleared to 0).
- Glitch rules:
  - x1/x2 only change while y=0, i.e. on entry to SETUP or IDLE.
  - y never changes in the same cycle as x1/x2.
- Timing:
  - Per-request period is HOLD_CYCLES+2 cycles back-to-back.
  - Latency from accept edge E0 to the first SETUP cycle: SETUP outputs are valid after E1; y=data after E2.
- Data values:
  - Requests with in_data=0 still run the full SETUP/DRIVE/GAP sequence: y stays 0, done still pulses.
- Stability: FIFO order is strictly preserved; outputs change only on clk edges.

Test Plan:
- Reset then idle, no in_valid for 10 cycles -> y=x1=x2=0, busy=0, in_ready=1, count=0 throughout.
- Single push chan=2, data=1 at E0 (HOLD=2):
  - After E1: x1=1, x2=0, y=0.
  - After E2 and E3: y=1.
  - After E4: y=0, done=1.
  - After E5: IDLE, x1=x2=0, busy=0.
- Four back-to-back pushes chan=0,1,2,3 all data=1:
  - Demux sees z0,z1,z2,z3 pulses in order, each 2 cycles wide, 4-cycle period.
  - done pulses 4 times; count peaks at 3.
- Fill to DEPTH=4 while the FSM is busy:
  - in_ready drops with count=4.
  - A 5th in_valid is held off until the next pop; the entry is accepted on the edge after in_ready rises.
  - No request is lost or reordered.
- Push data=0 on chan=3 -> x1=x2=1 for 4 cycles, y stays 0, done pulses once.
- Assert rst during DRIVE with 2 entries queued -> after that edge y=x1=x2=0, count=0, busy=0; queued entries never appear.
